// File: rtl/vec_normalize.sv
// Normalises a signed 3-D vector to unit length: holds the operands for an inverse
// square root, then scales each component by the 1Q24 result with round-half-up and saturation.

// Inverse square root in the same operand format as the vector (1 unit = 2^22).
// It computes out = min(floor(2^46 / floor(sqrt(x^2+y^2+z^2))), 2^25-1), with r==0 saturating.
// It has no reset, and out is valid exactly LAT edges after x/y/z settle.
module inv_sqrt #(
    parameter int LAT = 11
) (
    input  logic               clk,
    input  logic signed [23:0] x,
    input  logic signed [23:0] y,
    input  logic signed [23:0] z,
    output logic        [24:0] out
);
    logic signed [47:0] px, py, pz;
    logic        [47:0] ssq_c, ssq_r;
    logic        [23:0] root_r;
    logic        [46:0] quot;
    logic        [24:0] q_c;
    logic [LAT-3:0][24:0] pipe;

    function automatic logic [23:0] isqrt(input logic [47:0] v);
        logic [23:0] root, t;
        root = '0;
        for (int i = 23; i >= 0; i--) begin
            t = root | (24'd1 << i);
            if (48'(t) * 48'(t) <= v) root = t;
        end
        return root;
    endfunction

    always_comb begin
        px    = x * x;
        py    = y * y;
        pz    = z * z;
        ssq_c = $unsigned(px) + $unsigned(py) + $unsigned(pz);
    end

    always_comb begin
        quot = '0;
        q_c  = 25'h1FFFFFF;
        if (root_r != '0) begin
            quot = (47'd1 << 46) / 47'(root_r);
            if (quot <= 47'h1FFFFFF) q_c = quot[24:0];
        end
    end

    // Two compute stages, then a delay line that pads the total to LAT registers.
    always_ff @(posedge clk) begin
        ssq_r   <= ssq_c;
        root_r  <= isqrt(ssq_r);
        pipe[0] <= q_c;
        for (int i = 1; i <= LAT - 3; i++) pipe[i] <= pipe[i-1];
    end

    assign out = pipe[LAT-3];
endmodule

module vec_normalize #(
    parameter int INV_LAT = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_x,
    input  logic [23:0] in_y,
    input  logic [23:0] in_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_x,
    output logic [23:0] out_y,
    output logic [23:0] out_z,
    output logic        out_zero
);
    localparam int CW = $clog2(INV_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, MUL, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic signed [23:0] hold_x, hold_y, hold_z;
    logic        [24:0] inv_r, inv_out;
    logic               is_zero;

    inv_sqrt #(.LAT(INV_LAT)) u_inv (
        .clk (clk),
        .x   (hold_x),
        .y   (hold_y),
        .z   (hold_z),
        .out (inv_out)
    );

    function automatic logic [23:0] scale(input logic signed [23:0] c, input logic [24:0] inv);
        logic signed [49:0] p, r;
        p = c * $signed({1'b0, inv});
        r = (p + 50'sd8388608) >>> 24;
        if (r > 50'sd8388607)       return 24'h7FFFFF;
        else if (r < -50'sd8388608) return 24'h800000;
        else                        return r[23:0];
    endfunction

    assign in_ready = (state == IDLE);
    assign is_zero  = (hold_x == '0) && (hold_y == '0) && (hold_z == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)              state_nx = WAIT;
            WAIT: if (cnt == CW'(INV_LAT))   state_nx = MUL;
            MUL:                             state_nx = DONE;
            DONE: if (out_ready)             state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_x    <= '0;
            hold_y    <= '0;
            hold_z    <= '0;
            inv_r     <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    hold_x <= in_x;
                    hold_y <= in_y;
                    hold_z <= in_z;
                    cnt    <= '0;
                end
                // cnt parks at INV_LAT, so it never wraps.
                WAIT: if (cnt == CW'(INV_LAT)) inv_r <= inv_out;
                      else                     cnt   <= cnt + CW'(1);
                MUL: begin
                    out_x     <= is_zero ? '0 : scale(hold_x, inv_r);
                    out_y     <= is_zero ? '0 : scale(hold_y, inv_r);
                    out_z     <= is_zero ? '0 : scale(hold_z, inv_r);
                    out_zero  <= is_zero;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
